// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage register: FSM state encoding,
// packed control payload and the bubble value used when a beat is squashed.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic [1:0] alucontrol;
    logic       alusrc;
    logic       regdst;
  } ctrl_t;

  localparam int CTRL_BITS = $bits(ctrl_t);

  // An all-zero control word cannot write the register file or memory.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; it sticks at its
// maximum value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush to a bubble and a saturating stall-cycle counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = CTRL_BITS,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  output state_t            state_dbg
);

  // Handshake contract: a beat moves on a port only in a cycle where both
  // valid and ready are high at the rising edge; valid never waits on ready.

  state_t            state_q, state_d;
  logic              main_valid, skid_valid;
  logic              acc, take;
  logic              load_main, load_skid, skid_to_main;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == TWO);

  // With the skid buffer in_ready depends only on state, breaking the
  // combinational path from out_ready back upstream.
  assign in_ready  = SKID_EN ? !skid_valid : (!main_valid || out_ready);
  assign out_valid = main_valid;
  assign acc       = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else if (SKID_EN) begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (acc && take) begin
            load_main = 1'b1;
          end else if (acc) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (take) begin
            state_d      = ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      if (acc) begin
        state_d   = ONE;
        load_main = 1'b1;
      end else if (take) begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath payload carries no reset; stale values are harmless once invalid.
  always_ff @(posedge clk) begin
    if (load_main) begin
      main_data <= in_data;
    end else if (skid_to_main) begin
      main_data <= skid_data;
    end
    if (load_skid) begin
      skid_data <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ctrl <= CTRL_W'(CTRL_BUBBLE);
      skid_ctrl <= CTRL_W'(CTRL_BUBBLE);
    end else if (flush) begin
      main_ctrl <= CTRL_W'(CTRL_BUBBLE);
      skid_ctrl <= CTRL_W'(CTRL_BUBBLE);
    end else begin
      if (load_main) begin
        main_ctrl <= in_ctrl;
      end else if (skid_to_main) begin
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
      end
    end
  end

  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : CTRL_W'(CTRL_BUBBLE);
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign state_dbg = state_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid && !out_ready && !flush),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a skid-buffer instance (4-bit stall counter)
// and a single-register instance, checked by directed values and scoreboards.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: skid buffer enabled, 4-bit stall counter
  logic        rst_n_a, in_valid_a, in_ready_a, flush_a, out_valid_a, out_ready_a;
  logic [31:0] in_data_a, out_data_a;
  logic [7:0]  in_ctrl_a, out_ctrl_a;
  logic [1:0]  occ_a;
  logic [3:0]  stall_a;
  state_t      state_a;

  // Instance B: single register, combinational in_ready
  logic        rst_n_b, in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b;
  logic [31:0] in_data_b, out_data_b;
  logic [7:0]  in_ctrl_b, out_ctrl_b;
  logic [1:0]  occ_b;
  logic [15:0] stall_b;
  state_t      state_b;

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_ctrl(in_ctrl_a), .flush(flush_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_ctrl(out_ctrl_a), .occupancy(occ_a), .stall_cycles(stall_a),
    .state_dbg(state_a)
  );

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_ctrl(in_ctrl_b), .flush(flush_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_ctrl(out_ctrl_b), .occupancy(occ_b), .stall_cycles(stall_b),
    .state_dbg(state_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: {ctrl, data} of each accepted beat, in acceptance order
  logic [39:0] exp_a[$];
  logic [39:0] exp_b[$];
  logic [39:0] ea, eb;
  int          max_occ_b = 0;

  always @(negedge clk) begin
    if (rst_n_a) begin
      if (flush_a) begin
        exp_a.delete();
      end else begin
        if (out_valid_a && out_ready_a) begin
          if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_a_extra: got %0h expected none", out_data_a);
          end else begin
            ea = exp_a.pop_front();
            chk("sb_a_beat", {24'h0, out_ctrl_a, out_data_a}, {24'h0, ea});
          end
        end
        if (in_valid_a && in_ready_a) exp_a.push_back({in_ctrl_a, in_data_a});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n_b) begin
      if (int'(occ_b) > max_occ_b) max_occ_b = int'(occ_b);
      if (flush_b) begin
        exp_b.delete();
      end else begin
        if (out_valid_b && out_ready_b) begin
          if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_b_extra: got %0h expected none", out_data_b);
          end else begin
            eb = exp_b.pop_front();
            chk("sb_b_beat", {24'h0, out_ctrl_b, out_data_b}, {24'h0, eb});
          end
        end
        if (in_valid_b && in_ready_b) exp_b.push_back({in_ctrl_b, in_data_b});
      end
    end
  end

  // Drive one cycle's inputs just after the edge, return at the sampling edge
  task automatic drive_a(input logic v, input logic [31:0] d, input logic [7:0] c,
                         input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid_a  = v;
    in_data_a   = d;
    in_ctrl_a   = c;
    out_ready_a = rdy;
    flush_a     = fl;
    @(negedge clk);
  endtask

  task automatic drive_b(input logic v, input logic [31:0] d, input logic [7:0] c,
                         input logic rdy);
    @(posedge clk);
    #1;
    in_valid_b  = v;
    in_data_b   = d;
    in_ctrl_b   = c;
    out_ready_b = rdy;
    @(negedge clk);
  endtask

  initial begin
    rst_n_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; in_ctrl_a = '0;
    flush_a = 1'b0; out_ready_a = 1'b0;
    rst_n_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; in_ctrl_b = '0;
    flush_b = 1'b0; out_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(negedge clk);
    chk("a_rst_out_valid", out_valid_a, 1'b0);
    chk("a_rst_occ", occ_a, 2'd0);
    chk("a_rst_in_ready", in_ready_a, 1'b1);
    chk("a_rst_ctrl", out_ctrl_a, 8'h00);
    chk("a_rst_stall", stall_a, 4'd0);
    chk("a_rst_state", state_a, EMPTY);
    chk("b_rst_out_valid", out_valid_b, 1'b0);
    chk("b_rst_in_ready", in_ready_b, 1'b1);

    // Streaming, one beat per cycle, 1-cycle latency
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b1, 32'(i), 8'h81, 1'b1, 1'b0);
      chk("a_stream_in_ready", in_ready_a, 1'b1);
      chk("a_stream_out_valid", out_valid_a, (i > 1));
      if (i > 1) chk("a_stream_data", out_data_a, 64'(i - 1));
    end
    drive_a(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("a_stream_last_valid", out_valid_a, 1'b1);
    chk("a_stream_last_data", out_data_a, 32'h8);
    drive_a(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("a_stream_drained", out_valid_a, 1'b0);
    chk("a_ctrl_gated_empty", out_ctrl_a, 8'h00);
    chk("a_stream_stall", stall_a, 4'd0);

    // Backpressure fills the skid entry and holds off the third beat
    drive_a(1'b1, 32'hA, 8'h11, 1'b1, 1'b0);
    drive_a(1'b1, 32'hB, 8'h12, 1'b0, 1'b0);
    chk("a_bp_occ1", occ_a, 2'd1);
    chk("a_bp_head_A", out_data_a, 32'hA);
    drive_a(1'b1, 32'hC, 8'h13, 1'b0, 1'b0);
    chk("a_bp_occ2", occ_a, 2'd2);
    chk("a_bp_in_ready0", in_ready_a, 1'b0);
    chk("a_bp_state_two", state_a, TWO);
    chk("a_bp_stall1", stall_a, 4'd1);
    drive_a(1'b1, 32'hC, 8'h13, 1'b0, 1'b0);
    chk("a_bp_stall2", stall_a, 4'd2);
    drive_a(1'b1, 32'hC, 8'h13, 1'b1, 1'b0);
    chk("a_bp_release_A", out_data_a, 32'hA);
    chk("a_bp_stall3", stall_a, 4'd3);
    drive_a(1'b1, 32'hC, 8'h13, 1'b1, 1'b0);
    chk("a_bp_head_B", out_data_a, 32'hB);
    chk("a_bp_in_ready1", in_ready_a, 1'b1);
    drive_a(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("a_bp_head_C", out_data_a, 32'hC);
    chk("a_bp_ctrl_C", out_ctrl_a, 8'h13);
    drive_a(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("a_bp_empty", occ_a, 2'd0);
    chk("a_bp_stall_held", stall_a, 4'd3);

    // Flush while holding two beats; incoming beat discarded
    drive_a(1'b1, 32'h10, 8'hFF, 1'b0, 1'b0);
    drive_a(1'b1, 32'h11, 8'hFF, 1'b0, 1'b0);
    chk("a_fl_ctrl_ff", out_ctrl_a, 8'hFF);
    drive_a(1'b1, 32'h12, 8'h5A, 1'b0, 1'b1);
    chk("a_fl_occ2", occ_a, 2'd2);
    chk("a_fl_stall4", stall_a, 4'd4);
    drive_a(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("a_fl_out_valid", out_valid_a, 1'b0);
    chk("a_fl_out_ctrl", out_ctrl_a, 8'h00);
    chk("a_fl_occ0", occ_a, 2'd0);
    chk("a_fl_stall_nocount", stall_a, 4'd4);
    // Flush in ONE with a take and an accept in the same cycle
    drive_a(1'b1, 32'h13, 8'h33, 1'b1, 1'b0);
    drive_a(1'b1, 32'h14, 8'h44, 1'b1, 1'b1);
    chk("a_fl1_valid", out_valid_a, 1'b1);
    chk("a_fl1_in_ready", in_ready_a, 1'b1);
    drive_a(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("a_fl1_dropped", out_valid_a, 1'b0);
    chk("a_fl1_occ0", occ_a, 2'd0);

    // Asynchronous reset between edges while full
    drive_a(1'b1, 32'h20, 8'h22, 1'b0, 1'b0);
    drive_a(1'b1, 32'h21, 8'h23, 1'b0, 1'b0);
    drive_a(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("a_ar_occ2", occ_a, 2'd2);
    #1;
    rst_n_a = 1'b0;
    exp_a.delete();
    #1;
    chk("a_ar_out_valid", out_valid_a, 1'b0);
    chk("a_ar_occ", occ_a, 2'd0);
    chk("a_ar_stall", stall_a, 4'd0);
    chk("a_ar_ctrl", out_ctrl_a, 8'h00);
    @(posedge clk);
    #2;
    rst_n_a = 1'b1;
    drive_a(1'b1, 32'h55, 8'h55, 1'b1, 1'b0);
    chk("a_ar_lat0", out_valid_a, 1'b0);
    drive_a(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("a_ar_lat1_valid", out_valid_a, 1'b1);
    chk("a_ar_lat1_data", out_data_a, 32'h55);
    drive_a(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

    // Saturation of the 4-bit stall counter
    drive_a(1'b1, 32'h77, 8'h07, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      drive_a(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
      if (k == 6) chk("a_sat_5", stall_a, 4'd5);
      if (k == 17) chk("a_sat_15", stall_a, 4'd15);
      if (k == 20) chk("a_sat_hold", stall_a, 4'd15);
    end
    drive_a(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("a_sat_data", out_data_a, 32'h77);
    chk("a_sat_final", stall_a, 4'd15);
    drive_a(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

    // Single-register mode: in_ready follows out_ready combinationally
    drive_b(1'b1, 32'h31, 8'h31, 1'b1);
    chk("b_in_ready_empty", in_ready_b, 1'b1);
    drive_b(1'b1, 32'h32, 8'h32, 1'b1);
    chk("b_in_ready_r1", in_ready_b, 1'b1);
    chk("b_head_31", out_data_b, 32'h31);
    drive_b(1'b1, 32'h33, 8'h33, 1'b0);
    chk("b_in_ready_r0", in_ready_b, 1'b0);
    chk("b_occ1", occ_b, 2'd1);
    chk("b_head_32", out_data_b, 32'h32);
    drive_b(1'b1, 32'h33, 8'h33, 1'b1);
    chk("b_in_ready_r1b", in_ready_b, 1'b1);
    chk("b_head_32_held", out_data_b, 32'h32);
    chk("b_stall1", stall_b, 16'd1);
    drive_b(1'b0, 32'h0, 8'h00, 1'b1);
    chk("b_head_33", out_data_b, 32'h33);
    drive_b(1'b0, 32'h0, 8'h00, 1'b1);
    chk("b_empty", out_valid_b, 1'b0);
    chk("b_max_occ", max_occ_b, 1);

    chk("a_sb_drained", exp_a.size(), 0);
    chk("b_sb_drained", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised pipeline-stage register for the processor datapath. It generalises the fixed decode/execute latch with:
- a valid/ready handshake;
- an optional 2-entry skid buffer;
- a synchronous flush that inserts a bubble;
- an asynchronous reset;
- a saturating stall-cycle counter.

One instance sits between each pair of pipeline stages. Payload is split into datapath bits and control bits. Control bits are zeroed on a bubble so that a squashed instruction cannot write the register file or memory.

Parameters:
DATA_W, 32, width of datapath payload (operands, immediate, pc+4, register ids packed)
CTRL_W, 8, width of control payload (regwrite, memtoreg, memwrite, branch, alucontrol, alusrc, regdst packed)
SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of stall-cycle counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat this cycle
in_data  input  DATA_W  upstream datapath payload
in_ctrl  input  CTRL_W  upstream control payload
flush  input  1  synchronous squash of all held and incoming beats
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts beat
out_data  output  DATA_W  datapath payload of head entry
out_ctrl  output  CTRL_W  control payload of head entry; forced 0 when out_valid=0
occupancy  output  2  entries held (0..2; max 1 when SKID_EN=0)
stall_cycles  output  CNT_W  count of cycles with out_valid=1, out_ready=0, flush=0

Behaviour:
- Handshake definitions:
  - acc = in_valid & in_ready
  - take = out_valid & out_ready
- Reset (rst_n=0, asynchronous): state EMPTY; main and skid valid = 0; control registers = 0; out_valid=0; out_ctrl=0; occupancy=0; stall_cycles=0. Data registers are not reset. in_ready=1 while reset is deasserted and EMPTY.
- Latency: 1 cycle. A beat accepted at edge N is on out_* after edge N. Throughput is 1 beat/cycle when out_ready=1.
- SKID_EN=1 states (main/skid registers):
  - EMPTY: acc -> ONE, main<=in.
  - ONE:
    - acc&take -> ONE, main<=in.
    - acc&!take -> TWO, skid<=in.
    - !acc&take -> EMPTY.
    - neither -> hold.
  - TWO: take -> ONE, main<=skid. Otherwise hold.
  - in_ready = !skid_valid. It comes from a register, so there is no combinational path from out_ready.
- SKID_EN=0:
  - in_ready = !main_valid | out_ready (combinational).
  - acc -> main<=in, valid=1.
  - take&!acc -> valid=0.
  - TWO is unreachable.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- Flush (synchronous, highest priority):
  - At the edge: main and skid valid <= 0, control registers <= 0, state EMPTY.
  - Any beat accepted in the flush cycle is discarded.
  - A take in the flush cycle is permitted; downstream sees the beat as valid during that cycle. Downstream hazard logic gates its own capture with flush.
  - in_ready keeps its normal value during flush.
- Flush and reset: reset dominates flush.
- Reset mid-operation: all held beats are lost immediately, without waiting for a clock edge.
- out_ctrl gating: out_ctrl = out_valid ? main_ctrl : 0.
- out_data: always shows main_data, including stale values when empty.
- Stall counter:
  - Increments at each edge where out_valid=1, out_ready=0, flush=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- occupancy = main_valid + skid_valid.

Decomposition:
- Shared package pipe_pkg:
  - typedef state_t {EMPTY, ONE, TWO};
  - packed struct ctrl_t for the 8 control bits, with CTRL_W derived from $bits(ctrl_t);
  - localparam CTRL_BUBBLE = '0.
- One sub-module, sat_counter (width parameter, inc input, async active-low clear), used for stall_cycles.
- Skid/main storage stays in the top module.

Test Plan:
1. Streaming, SKID_EN=1: out_ready=1; drive data 0x1..0x8, ctrl 0x81, in_valid=1 for 8 cycles -> out_data 0x1..0x8 on consecutive cycles starting 1 cycle later; in_ready stays 1; stall_cycles=0.
2. Backpressure: stream 0xA,0xB,0xC; hold out_ready=0 from cycle 2 -> occupancy reaches 2 and in_ready=0; 0xC is held off upstream; stall_cycles increments each held cycle. Release out_ready -> output 0xA,0xB,0xC in order with no loss.
3. Flush in TWO: held beats 0x10,0x11 (ctrl 0xFF); assert flush with in_valid=1, data 0x12 -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0; 0x12 never appears.
4. Async reset mid-stream: pull rst_n low between edges while occupancy=2 -> out_valid and occupancy go to 0 immediately; after release, next beat 0x55 passes with 1-cycle latency.
5. Counter saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles = 15 and holds at 15.
6. SKID_EN=0: occupancy=1, out_ready toggling 1,0,1 -> in_ready follows out_ready in the same cycle; occupancy never exceeds 1; data order preserved.
